// File: rtl/axis_playback.sv
// AXI-Stream playback source: replays the first len words of a preloaded buffer
// onto a master stream port with full backpressure and a done pulse at the end.
module axis_playback #(
  parameter int DW     = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_mem [DEPTH];
  logic [DW-1:0]     r_rdata;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_sent;
  logic [ADDR_W:0]   r_len_q;
  logic [ADDR_W:0]   w_len_clamp;
  logic              w_busy;
  logic              w_accept;
  logic              w_last;
  logic              w_hs;

  assign w_busy      = (r_state == S_PRIME) || (r_state == S_STREAM);
  assign w_accept    = start && (len != '0) && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign w_last      = (r_sent == r_len_q - LEN_ONE);
  assign w_hs        = (r_state == S_STREAM) && m_tready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_PRIME;
      S_PRIME:  w_next = S_STREAM;
      S_STREAM: if (w_hs && w_last) w_next = S_DONE;
      S_DONE:   w_next = w_accept ? S_PRIME : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Writes are locked out during playback so the words in flight stay intact.
  always_ff @(posedge clk) begin
    if (wr_en && !w_busy) r_mem[wr_addr] <= wr_data;
  end

  // The word after the current beat is fetched on each handshake, sustaining one
  // beat per cycle; no fetch follows the last beat, so the pointer never wraps.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_len_q  <= '0;
      r_sent   <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      r_len_q  <= w_len_clamp;
      r_sent   <= '0;
      r_rd_ptr <= '0;
    end else if (r_state == S_PRIME) begin
      r_rdata  <= r_mem[r_rd_ptr];
    end else if (w_hs) begin
      r_sent <= r_sent + LEN_ONE;
      if (!w_last) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_rdata  <= r_mem[r_rd_ptr + PTR_ONE];
      end
    end
  end

  assign busy     = w_busy;
  assign done     = (r_state == S_DONE);
  assign m_tvalid = (r_state == S_STREAM);
  assign m_tlast  = (r_state == S_STREAM) && w_last;
  assign m_tdata  = r_rdata;

endmodule

// File: tb/tb_axis_playback.sv
// Directed-plus-random bench for axis_playback; expected beats come from a
// word-array model of the buffer and the playback rules.
module tb_axis_playback;

  logic        clk = 1'b0;
  logic        arst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  int checks   = 0;
  int failures = 0;
  logic [63:0] model_mem [16];

  axis_playback #(.DW(64), .DEPTH(16)) dut (
    .clk(clk), .arst(arst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .busy(busy), .done(done), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [63:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random ready
  task automatic play(input int len_in, input int mode, input int abort_at,
                      input int next_len, input bit prestarted, input bit inject);
    int L, k, cyc;
    bit injected;
    injected = 0;
    if (!prestarted) begin
      @(negedge clk); start = 1'b1; len = 5'(len_in);
    end
    @(negedge clk); start = 1'b0; len = '0;
    #1;
    if (len_in == 0) begin
      for (int i = 0; i < 4; i++) begin
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_valid", 64'(m_tvalid), 64'd0);
        chk("zero_done", 64'(done), 64'd0);
        @(negedge clk); #1;
      end
      return;
    end
    L = (len_in > 16) ? 16 : len_in;
    chk("prime_busy", 64'(busy), 64'd1);
    chk("prime_valid", 64'(m_tvalid), 64'd0);
    k = 0; cyc = 0;
    while (k < L && cyc < 300) begin
      @(negedge clk);
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 3 == 0);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (inject && !injected && k == 1) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 64'hDEAD;
        start = 1'b1; len = 5'd3; injected = 1;
      end else begin
        wr_en = 1'b0; start = 1'b0; len = '0;
      end
      #1;
      chk("valid", 64'(m_tvalid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("tdata", m_tdata, model_mem[k]);
      chk("tlast", 64'(m_tlast), 64'(k == L - 1));
      cyc++;
      if (m_tready) begin
        k++;
        if (abort_at > 0 && k == abort_at) begin
          @(posedge clk); #2;
          arst = 1'b1; #1;
          chk("abort_valid", 64'(m_tvalid), 64'd0);
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_last", 64'(m_tlast), 64'd0);
          chk("abort_done", 64'(done), 64'd0);
          @(negedge clk); @(negedge clk);
          arst = 1'b0;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_abort_done", 64'(done), 64'd0);
            chk("post_abort_valid", 64'(m_tvalid), 64'd0);
          end
          return;
        end
      end
    end
    chk("beats", 64'(k), 64'(L));
    if (mode == 0) chk("cycles", 64'(cyc), 64'(L));
    @(negedge clk);
    wr_en = 1'b0;
    if (next_len > 0) begin start = 1'b1; len = 5'(next_len); end
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_valid", 64'(m_tvalid), 64'd0);
    if (next_len == 0) begin
      @(negedge clk); #1;
      chk("done_once", 64'(done), 64'd0);
      chk("idle_valid", 64'(m_tvalid), 64'd0);
    end
  endtask

  initial begin
    arst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(m_tvalid), 64'd0);
    chk("rst_last", 64'(m_tlast), 64'd0);
    chk("rst_data", m_tdata, 64'd0);
    @(negedge clk); arst = 1'b0;

    for (int i = 0; i < 16; i++) write_word(i, 64'h100 + 64'(i));
    play(16, 0, 0, 0, 0, 0);
    play(5, 1, 0, 0, 0, 0);
    play(0, 0, 0, 0, 0, 0);
    play(20, 0, 0, 0, 0, 0);
    play(8, 2, 0, 0, 0, 1);
    play(4, 0, 0, 0, 0, 0);
    play(8, 0, 3, 0, 0, 0);
    play(8, 0, 0, 0, 0, 0);
    play(2, 0, 0, 3, 0, 0);
    play(3, 0, 0, 0, 1, 0);

    for (int i = 0; i < 16; i++) write_word(i, {$urandom, $urandom});
    for (int r = 0; r < 6; r++) play(int'($urandom_range(1, 20)), 2, 0, 0, 0, 0);
    play(1, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
